// File: rtl/sc_game_pkg.sv
// rtl/sc_game_pkg.sv - shared screen codes and limits for the Frogger game sequencer
package sc_game_pkg;

    localparam logic [2:0] START     = 3'b001;
    localparam logic [2:0] WIN       = 3'b010;
    localparam logic [2:0] LOSE      = 3'b011;
    localparam logic [2:0] PLAY      = 3'b100;
    localparam logic [2:0] CHECK     = 3'b101;
    localparam logic [2:0] SHOWLEVEL = 3'b110;

    localparam int LEVEL_MAX_DEFAULT = 4;

    localparam logic [2:0] FROG_TOP_ROW = 3'b111;

endpackage

// File: rtl/sc_edge_detector_low.sv
// rtl/sc_edge_detector_low.sv - registered falling-edge detector for an active-low button
module sc_edge_detector_low (
    input  logic clk,
    input  logic rst,
    input  logic in_low,
    output logic press
);

    logic prev_q, prev_d;
    logic press_q, press_d;

    always_comb begin
        prev_d  = in_low;
        press_d = prev_q & ~in_low;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b1;
            press_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/sc_game_sequencer.sv
// rtl/sc_game_sequencer.sv - game FSM driving screen code, level, load strobe and frog reset
module sc_game_sequencer
    import sc_game_pkg::*;
#(
    parameter int DATAWIDTH_STATE         = 3,
    parameter int DATAWIDTH_LEVEL         = 3,
    parameter int FROGGPOSITION_DATAWIDTH = 3,
    parameter int DWELL_TICKS             = 4,
    parameter int DWELL_WIDTH             = 4,
    parameter int LEVEL_MAX               = LEVEL_MAX_DEFAULT
) (
    input  logic                               SC_GAMESEQUENCER_CLOCK_50,
    input  logic                               SC_GAMESEQUENCER_RESET_InHigh,
    input  logic                               SC_GAMESEQUENCER_start_InLow,
    input  logic                               SC_GAMESEQUENCER_tick_InHigh,
    input  logic                               SC_GAMESEQUENCER_collision_InHigh,
    input  logic [FROGGPOSITION_DATAWIDTH-1:0] SC_GAMESEQUENCER_positionY_data_InBus,
    output logic [DATAWIDTH_STATE-1:0]         SC_GAMESEQUENCER_state_data_OutBus,
    output logic [DATAWIDTH_LEVEL-1:0]         SC_GAMESEQUENCER_level_data_OutBus,
    output logic                               SC_GAMESEQUENCER_load_OutLow,
    output logic                               SC_GAMESEQUENCER_frogreset_OutLow
);

    localparam logic [DWELL_WIDTH-1:0]     DWELL_TGT = DWELL_WIDTH'(DWELL_TICKS);
    localparam logic [DATAWIDTH_LEVEL-1:0] LVL_ONE   = DATAWIDTH_LEVEL'(1);
    localparam logic [DATAWIDTH_LEVEL-1:0] LVL_LAST  = DATAWIDTH_LEVEL'(LEVEL_MAX);

    logic                       clk, rst, press;
    logic [DATAWIDTH_STATE-1:0] state_q, state_d;
    logic [DATAWIDTH_LEVEL-1:0] level_q, level_d;
    logic [DWELL_WIDTH-1:0]     dwell_q, dwell_d;
    logic                       load_q, load_d;
    logic                       frogreset_q, frogreset_d;
    logic                       pending_q, pending_d;
    logic                       dwell_done, allow, transition;

    assign clk = SC_GAMESEQUENCER_CLOCK_50;
    assign rst = SC_GAMESEQUENCER_RESET_InHigh;

    sc_edge_detector_low u_start_edge (
        .clk    (clk),
        .rst    (rst),
        .in_low (SC_GAMESEQUENCER_start_InLow),
        .press  (press)
    );

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        dwell_d    = dwell_q;
        pending_d  = 1'b0;
        // Counter saturates so a completed dwell survives a deferred exit.
        if ((state_q == SHOWLEVEL || state_q == CHECK) && SC_GAMESEQUENCER_tick_InHigh
            && dwell_q != DWELL_TGT) begin
            dwell_d = dwell_q + DWELL_WIDTH'(1);
        end
        dwell_done = (dwell_d == DWELL_TGT);
        // Hold transitions off while a load pulse is on the output so strobes stay separated.
        allow = load_q;
        case (state_q)
            START: begin
                if (press && allow) begin
                    state_d = SHOWLEVEL;
                    level_d = LVL_ONE;
                end
            end
            SHOWLEVEL: begin
                if (dwell_done && allow) state_d = PLAY;
            end
            PLAY: begin
                if (allow) begin
                    if (SC_GAMESEQUENCER_collision_InHigh)                           state_d = LOSE;
                    else if (SC_GAMESEQUENCER_positionY_data_InBus == FROG_TOP_ROW) state_d = CHECK;
                end
            end
            CHECK: begin
                if (dwell_done && allow) begin
                    if (level_q == LVL_LAST) begin
                        state_d = WIN;
                    end else begin
                        state_d = SHOWLEVEL;
                        level_d = level_q + LVL_ONE;
                    end
                end
            end
            WIN, LOSE: begin
                if (press && allow) state_d = START;
            end
            default: state_d = START;
        endcase
        transition = (state_d != state_q);
        if (transition) dwell_d = '0;
        load_d      = ~(transition | pending_q);
        frogreset_d = (state_d == PLAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= START;
            level_q     <= LVL_ONE;
            dwell_q     <= '0;
            load_q      <= 1'b1;
            frogreset_q <= 1'b0;
            pending_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            dwell_q     <= dwell_d;
            load_q      <= load_d;
            frogreset_q <= frogreset_d;
            pending_q   <= pending_d;
        end
    end

    assign SC_GAMESEQUENCER_state_data_OutBus = state_q;
    assign SC_GAMESEQUENCER_level_data_OutBus = level_q;
    assign SC_GAMESEQUENCER_load_OutLow       = load_q;
    assign SC_GAMESEQUENCER_frogreset_OutLow  = frogreset_q;

endmodule
